md_unit: RTL and testbench

- Parametrised multiply/divide unit for the pipelined MIPS core; sits in stage E beside the ALU.
- Owns the HI/LO registers. Executes mult/multu/div/divu/mthi/mtlo, plus new accumulate modes madd/maddu/msub/msubu.
- Exposes busy so the hazard unit can stall any md-class instruction in D.
- Supports exception flush (cancel) of an in-flight operation.

---
 rtl/md_unit_pkg.sv | 36 +++
 rtl/md_unit_core.sv | 41 ++++
 rtl/md_unit.sv | 99 +++++++++
 tb/tb_md_unit.sv | 131 +++++++++++++
 4 files changed

// File: rtl/md_unit_pkg.sv
// md_unit_pkg: operation codes, FSM states and op-class helpers for the multiply/divide unit
package md_unit_pkg;

    localparam logic [3:0] MD_NONE  = 4'd0;
    localparam logic [3:0] MD_MULT  = 4'd1;
    localparam logic [3:0] MD_MULTU = 4'd2;
    localparam logic [3:0] MD_DIV   = 4'd3;
    localparam logic [3:0] MD_DIVU  = 4'd4;
    localparam logic [3:0] MD_MTHI  = 4'd5;
    localparam logic [3:0] MD_MTLO  = 4'd6;
    localparam logic [3:0] MD_MADD  = 4'd7;
    localparam logic [3:0] MD_MADDU = 4'd8;
    localparam logic [3:0] MD_MSUB  = 4'd9;
    localparam logic [3:0] MD_MSUBU = 4'd10;

    typedef enum logic {IDLE, RUN} md_state_t;

    // Ops that occupy the unit for a multi-cycle latency (hazard unit stalls on these)
    function automatic logic md_is_busy(input logic [3:0] op);
        return op inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU};
    endfunction

    // Ops that read HI/LO as an accumulate base or write them directly
    function automatic logic md_is_rd(input logic [3:0] op);
        return op inside {MD_MTHI, MD_MTLO, MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU};
    endfunction

    function automatic logic md_is_div(input logic [3:0] op);
        return op inside {MD_DIV, MD_DIVU};
    endfunction

    function automatic logic md_is_signed(input logic [3:0] op);
        return op inside {MD_MULT, MD_DIV, MD_MADD, MD_MSUB};
    endfunction

endpackage

// File: rtl/md_unit_core.sv
// md_unit_core: combinational multiply/accumulate/divide producing the next {hi,lo}
module md_unit_core
    import md_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] hi,
    input  logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi_n,
    output logic [WIDTH-1:0] lo_n
);

    logic             w_sgn;
    logic [2*WIDTH-1:0] w_ea, w_eb, w_prod, w_acc, w_res;
    logic [WIDTH-1:0] w_ma, w_mb, w_uq, w_ur, w_q, w_r;

    // Extend to 2W so one unsigned multiply yields the exact low 2W bits for either signedness;
    // divide works on magnitudes so the most-negative / -1 case wraps to most-negative with zero remainder
    always_comb begin
        w_sgn  = md_is_signed(op);
        w_ea   = {{WIDTH{w_sgn & a[WIDTH-1]}}, a};
        w_eb   = {{WIDTH{w_sgn & b[WIDTH-1]}}, b};
        w_prod = w_ea * w_eb;
        w_acc  = {hi, lo};
        w_ma   = (w_sgn && a[WIDTH-1]) ? -a : a;
        w_mb   = (w_sgn && b[WIDTH-1]) ? -b : b;
        w_uq   = (b == '0) ? '0 : w_ma / w_mb;
        w_ur   = (b == '0) ? '0 : w_ma % w_mb;
        w_q    = (w_sgn && (a[WIDTH-1] ^ b[WIDTH-1])) ? -w_uq : w_uq;
        w_r    = (w_sgn && a[WIDTH-1]) ? -w_ur : w_ur;
        w_res  = (op inside {MD_MULT, MD_MULTU}) ? w_prod :
                 (op inside {MD_MADD, MD_MADDU}) ? w_acc + w_prod :
                 (op inside {MD_MSUB, MD_MSUBU}) ? w_acc - w_prod :
                 (md_is_div(op) && b != '0)      ? {w_r, w_q} : w_acc;
        {hi_n, lo_n} = w_res;
    end

endmodule

// File: rtl/md_unit.sv
// md_unit: HI/LO owner with fixed-latency multiply/divide, busy for hazard stall, and cancel
module md_unit
    import md_unit_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       md_op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2((MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES) + 1);

    md_state_t        r_state, w_state_n;
    logic [CW-1:0]    r_cnt;
    logic [3:0]       r_op;
    logic [WIDTH-1:0] r_a, r_b, r_hi, r_lo, w_hi_n, w_lo_n;
    logic             w_load, w_done, w_mthi, w_mtlo;

    md_unit_core #(.WIDTH(WIDTH)) u_core (
        .op   (r_op),
        .a    (r_a),
        .b    (r_b),
        .hi   (r_hi),
        .lo   (r_lo),
        .hi_n (w_hi_n),
        .lo_n (w_lo_n)
    );

    assign busy = (r_state == RUN);
    assign hi   = r_hi;
    assign lo   = r_lo;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_n;
    end

    // Next state and control strobes; cancel beats both a new start and a completing op
    always_comb begin
        w_state_n = r_state;
        w_load    = 1'b0;
        w_done    = 1'b0;
        w_mthi    = 1'b0;
        w_mtlo    = 1'b0;
        if (r_state == IDLE) begin
            if (start && !cancel) begin
                w_load    = md_is_busy(md_op);
                w_mthi    = (md_op == MD_MTHI);
                w_mtlo    = (md_op == MD_MTLO);
                w_state_n = w_load ? RUN : IDLE;
            end
        end else if (cancel) begin
            w_state_n = IDLE;
        end else if (r_cnt == CW'(1)) begin
            w_done    = 1'b1;
            w_state_n = IDLE;
        end
    end

    // Operand latch, latency counter and HI/LO registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
            r_op  <= MD_NONE;
            r_a   <= '0;
            r_b   <= '0;
            r_hi  <= '0;
            r_lo  <= '0;
        end else begin
            if (w_load) begin
                r_op  <= md_op;
                r_a   <= a;
                r_b   <= b;
                r_cnt <= md_is_div(md_op) ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
            end else if (r_state == RUN) begin
                r_cnt <= cancel ? '0 : r_cnt - CW'(1);
            end
            if (w_done) begin
                r_hi <= w_hi_n;
                r_lo <= w_lo_n;
            end else begin
                if (w_mthi) r_hi <= a;
                if (w_mtlo) r_lo <= a;
            end
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed vectors with hand-computed HI/LO and busy-length expectations
module tb_md_unit;
    import md_unit_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  md_op = MD_NONE;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        cancel = 1'b0;
    logic        busy;
    logic [31:0] hi, lo;
    int          n_chk = 0;
    int          n_fail = 0;

    md_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .md_op  (md_op),
        .a      (a),
        .b      (b),
        .cancel (cancel),
        .busy   (busy),
        .hi     (hi),
        .lo     (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one op at a negedge, count busy cycles (bounded), then check HI/LO
    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                          input int exp_n, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int n;
        @(negedge clk);
        start = 1'b1; md_op = op; a = x; b = y;
        @(negedge clk);
        start = 1'b0; md_op = MD_NONE;
        n = 0;
        while (busy && n < 100) begin
            n++;
            @(negedge clk);
        end
        check({tag, " busy"}, 64'(n), 64'(exp_n));
        check({tag, " hi"}, 64'(hi), 64'(exp_hi));
        check({tag, " lo"}, 64'(lo), 64'(exp_lo));
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("reset busy", 64'(busy), 64'(0));
        check("reset hi", 64'(hi), 64'(0));
        check("reset lo", 64'(lo), 64'(0));
        reset = 1'b0;

        run_op("mult",   MD_MULT,  32'hFFFFFFFD, 32'd5,        5,  32'hFFFFFFFF, 32'hFFFFFFF1);
        run_op("multu",  MD_MULTU, 32'hFFFFFFFF, 32'd2,        5,  32'h00000001, 32'hFFFFFFFE);
        run_op("div",    MD_DIV,   32'hFFFFFFF9, 32'd2,        10, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("divneg", MD_DIV,   32'd7,        32'hFFFFFFFE, 10, 32'h00000001, 32'hFFFFFFFD);
        run_op("divu",   MD_DIVU,  32'd7,        32'd2,        10, 32'h00000001, 32'h00000003);
        run_op("mthi",   MD_MTHI,  32'd1,        32'd0,        0,  32'h00000001, 32'h00000003);
        run_op("mtlo",   MD_MTLO,  32'd2,        32'd0,        0,  32'h00000001, 32'h00000002);
        run_op("madd",   MD_MADD,  32'd3,        32'd4,        5,  32'h00000001, 32'h0000000E);
        run_op("msubu",  MD_MSUBU, 32'd1,        32'h0F,       5,  32'h00000000, 32'hFFFFFFFF);
        run_op("mtlo0",  MD_MTLO,  32'd0,        32'd0,        0,  32'h00000000, 32'h00000000);
        run_op("msub",   MD_MSUB,  32'hFFFFFFFF, 32'd1,        5,  32'h00000000, 32'h00000001);
        run_op("maddu",  MD_MADDU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5,  32'hFFFFFFFE, 32'h00000002);
        run_op("mthiAA", MD_MTHI,  32'hAA,       32'd0,        0,  32'h000000AA, 32'h00000002);
        run_op("mtloBB", MD_MTLO,  32'hBB,       32'd0,        0,  32'h000000AA, 32'h000000BB);
        run_op("div0",   MD_DIV,   32'd5,        32'd0,        10, 32'h000000AA, 32'h000000BB);
        run_op("divovf", MD_DIV,   32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000);
        run_op("unused", 4'd13,    32'h12345678, 32'd3,        0,  32'h00000000, 32'h80000000);

        // cancel in the 3rd busy cycle; an mthi during busy must be ignored
        @(negedge clk);
        start = 1'b1; md_op = MD_MULTU; a = 32'd9; b = 32'd9;
        @(negedge clk);
        start = 1'b0; md_op = MD_NONE;
        check("cancel busy1", 64'(busy), 64'(1));
        @(negedge clk);
        start = 1'b1; md_op = MD_MTHI; a = 32'hDEAD;
        @(negedge clk);
        start = 1'b0; md_op = MD_NONE;
        cancel = 1'b1;
        check("cancel busy3", 64'(busy), 64'(1));
        @(negedge clk);
        cancel = 1'b0;
        check("cancel busy off", 64'(busy), 64'(0));
        repeat (8) @(negedge clk);
        check("cancel busy stays", 64'(busy), 64'(0));
        check("cancel hi", 64'(hi), 64'(0));
        check("cancel lo", 64'(lo), 64'(32'h80000000));

        // cancel with a same-cycle start suppresses both mtlo and arithmetic ops
        start = 1'b1; cancel = 1'b1; md_op = MD_MTLO; a = 32'h5555;
        @(negedge clk);
        md_op = MD_MULT;
        @(negedge clk);
        start = 1'b0; cancel = 1'b0; md_op = MD_NONE;
        check("cxl mtlo busy", 64'(busy), 64'(0));
        check("cxl mtlo lo", 64'(lo), 64'(32'h80000000));

        // async reset in the middle of a divide
        run_op("pre", MD_MTHI, 32'h77, 32'd0, 0, 32'h00000077, 32'h80000000);
        start = 1'b1; md_op = MD_DIVU; a = 32'd100; b = 32'd7;
        @(negedge clk);
        start = 1'b0; md_op = MD_NONE;
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("arst busy", 64'(busy), 64'(0));
        check("arst hi", 64'(hi), 64'(0));
        check("arst lo", 64'(lo), 64'(0));
        @(negedge clk);
        reset = 1'b0;
        run_op("post", MD_DIVU, 32'd100, 32'd7, 10, 32'h00000002, 32'h0000000E);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
